// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types, widths and helpers for the data-memory lock arbiter.
package mem_lock_arbiter_pkg;

  // Data-memory word address and data widths.
  localparam int unsigned MEM_ADDR_W = 30;
  localparam int unsigned MEM_DATA_W = 32;

  // Widest issue_id the age helper handles. Narrower ids are zero-extended.
  localparam int unsigned MAX_ID_W = 16;

  // Wrap-aware age of an issue_id relative to the oldest in-flight id:
  // (id - oldest) mod 2^id_w, treated as unsigned. Smaller means older.
  function automatic logic [MAX_ID_W-1:0] age_of(logic [MAX_ID_W-1:0] id,
                                                 logic [MAX_ID_W-1:0] oldest,
                                                 int unsigned         id_w);
    logic [MAX_ID_W-1:0] mask;
    // When id_w == MAX_ID_W the shift gives 0 and the mask becomes all ones.
    mask = (MAX_ID_W'(1) << id_w) - MAX_ID_W'(1);
    return (id - oldest) & mask;
  endfunction

  // Bit offset of slot idx inside a flat per-SIC array of width-bit entries.
  function automatic int unsigned slot_lsb(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

  // Index width for n slots; at least one bit so single-SIC builds stay legal.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_age_picker.sv
// Combinational oldest-eligible selector: among eligible slots returns the one
// with the smallest wrap-aware age; ties go to the lower slot index.
module mem_age_picker
  import mem_lock_arbiter_pkg::*;
#(
  parameter int unsigned NumSic  = 4,
  parameter int unsigned IdWidth = 6,
  localparam int unsigned IdxW   = idx_width(NumSic)
) (
  input  logic [NumSic-1:0]         eligible_i,
  input  logic [NumSic*IdWidth-1:0] issue_id_i,
  input  logic [IdWidth-1:0]        oldest_id_i,
  output logic                      found_o,
  output logic [IdxW-1:0]           idx_o
);

  logic [IdWidth-1:0] best_age;
  logic [IdWidth-1:0] cur_age;

  // Linear scan in ascending index; strict less-than keeps the lower index on ties.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    best_age = '0;
    cur_age  = '0;
    for (int unsigned i = 0; i < NumSic; i++) begin
      cur_age = IdWidth'(age_of(MAX_ID_W'(issue_id_i[slot_lsb(i, IdWidth) +: IdWidth]),
                                MAX_ID_W'(oldest_id_i), IdWidth));
      if (eligible_i[i] && (!found_o || (cur_age < best_age))) begin
        found_o  = 1'b1;
        idx_o    = IdxW'(i);
        best_age = cur_age;
      end
    end
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Data-memory lock arbiter: grants the single data-memory port to the oldest
// requesting SIC (program order), holds ownership until release/abort/flush,
// and muxes the owner's word access onto the memory port.
module mem_lock_arbiter
  import mem_lock_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SIC  = 4,
  parameter int unsigned ID_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [ID_WIDTH-1:0]            oldest_id_i,
  input  logic [NUM_SIC-1:0]             sic_req_i,
  input  logic [NUM_SIC*ID_WIDTH-1:0]    sic_issue_id_i,
  input  logic [NUM_SIC-1:0]             sic_release_i,
  input  logic [NUM_SIC*MEM_ADDR_W-1:0]  sic_addr_i,
  input  logic [NUM_SIC*MEM_DATA_W-1:0]  sic_wdata_i,
  input  logic [NUM_SIC-1:0]             sic_wen_i,
  output logic [NUM_SIC-1:0]             sic_grant_o,
  output logic [MEM_DATA_W-1:0]          sic_rdata_o,
  output logic [MEM_ADDR_W-1:0]          dmem_addr_o,
  output logic [MEM_DATA_W-1:0]          dmem_wdata_o,
  output logic                           dmem_wen_o,
  input  logic [MEM_DATA_W-1:0]          dmem_rdata_i
);

  localparam int unsigned IdxW = idx_width(NUM_SIC);

  logic            owner_valid_q, owner_valid_d;
  logic [IdxW-1:0] owner_idx_q, owner_idx_d;

  logic [NUM_SIC-1:0] owner_onehot;
  logic [NUM_SIC-1:0] eligible;
  logic               owner_req;
  logic               owner_rel;
  logic               grant_active;
  logic               pick_found;
  logic [IdxW-1:0]    pick_idx;

  // Decode the current owner and exclude it from the next arbitration round.
  always_comb begin
    owner_onehot = '0;
    owner_req    = 1'b0;
    owner_rel    = 1'b0;
    if (owner_valid_q) begin
      owner_onehot[owner_idx_q] = 1'b1;
      owner_req                 = sic_req_i[owner_idx_q];
      owner_rel                 = sic_release_i[owner_idx_q];
    end
    eligible     = sic_req_i & ~owner_onehot;
    grant_active = owner_valid_q & owner_req & ~flush_i;
    sic_grant_o  = owner_onehot & {NUM_SIC{grant_active}};
  end

  mem_age_picker #(
    .NumSic  (NUM_SIC),
    .IdWidth (ID_WIDTH)
  ) u_picker (
    .eligible_i  (eligible),
    .issue_id_i  (sic_issue_id_i),
    .oldest_id_i (oldest_id_i),
    .found_o     (pick_found),
    .idx_o       (pick_idx)
  );

  // Route the granted owner's access to the memory port; idle port is all zero.
  always_comb begin
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_wen_o   = 1'b0;
    if (grant_active) begin
      dmem_addr_o  = sic_addr_i[slot_lsb(32'(owner_idx_q), MEM_ADDR_W) +: MEM_ADDR_W];
      dmem_wdata_o = sic_wdata_i[slot_lsb(32'(owner_idx_q), MEM_DATA_W) +: MEM_DATA_W];
      dmem_wen_o   = sic_wen_i[owner_idx_q];
    end
    sic_rdata_o = dmem_rdata_i;
  end

  // Ownership next-state: flush, then acquire, then release/abort reselect, else hold.
  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_idx_d   = owner_idx_q;
    if (flush_i) begin
      owner_valid_d = 1'b0;
    end else if (!owner_valid_q) begin
      if (pick_found) begin
        owner_valid_d = 1'b1;
        owner_idx_d   = pick_idx;
      end
    end else if ((grant_active && owner_rel) || !owner_req) begin
      // Picker already excludes the outgoing owner, so a single-SIC build
      // naturally idles one cycle before slot 0 can be granted again.
      owner_valid_d = pick_found;
      if (pick_found) begin
        owner_idx_d = pick_idx;
      end
    end
    if (NUM_SIC == 1) begin
      owner_idx_d = '0;
    end
  end

  // Ownership state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_idx_q   <= owner_idx_d;
    end
  end

  // Structural invariants of the grant and memory port.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(sic_grant_o))
        else $error("grant not one-hot: %b", sic_grant_o);
      assert (!dmem_wen_o || (sic_grant_o != '0))
        else $error("memory write without a grant");
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed bench for mem_lock_arbiter (NUM_SIC=4, ID_WIDTH=6).
module tb_mem_lock_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 6;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [IW-1:0]   oldest_id;
  logic [N-1:0]    sic_req;
  logic [N*IW-1:0] sic_issue_id;
  logic [N-1:0]    sic_release;
  logic [N*30-1:0] sic_addr;
  logic [N*32-1:0] sic_wdata;
  logic [N-1:0]    sic_wen;
  logic [N-1:0]    sic_grant;
  logic [31:0]     sic_rdata;
  logic [29:0]     dmem_addr;
  logic [31:0]     dmem_wdata;
  logic            dmem_wen;
  logic [31:0]     dmem_rdata;

  int n_vec;
  int n_err;

  mem_lock_arbiter #(
    .NUM_SIC  (N),
    .ID_WIDTH (IW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .oldest_id_i    (oldest_id),
    .sic_req_i      (sic_req),
    .sic_issue_id_i (sic_issue_id),
    .sic_release_i  (sic_release),
    .sic_addr_i     (sic_addr),
    .sic_wdata_i    (sic_wdata),
    .sic_wen_i      (sic_wen),
    .sic_grant_o    (sic_grant),
    .sic_rdata_o    (sic_rdata),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_wen_o     (dmem_wen),
    .dmem_rdata_i   (dmem_rdata)
  );

  // Combinational memory model: read data is a fixed function of the address.
  function automatic logic [31:0] rd_model(logic [29:0] a);
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction

  assign dmem_rdata = rd_model(dmem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".grant"}, 64'(sic_grant), 64'h0);
    check({tag, ".wen"},   64'(dmem_wen),  64'h0);
    check({tag, ".addr"},  64'(dmem_addr), 64'h0);
    check({tag, ".wdata"}, 64'(dmem_wdata), 64'h0);
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] g, input logic [29:0] a,
                              input logic [31:0] wd, input logic we);
    check({tag, ".grant"}, 64'(sic_grant), 64'(g));
    check({tag, ".addr"},  64'(dmem_addr), 64'(a));
    check({tag, ".wdata"}, 64'(dmem_wdata), 64'(wd));
    check({tag, ".wen"},   64'(dmem_wen),  64'(we));
    check({tag, ".rdata"}, 64'(sic_rdata), 64'(rd_model(a)));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    flush       = 1'b0;
    sic_req     = '0;
    sic_release = '0;
    sic_wen     = '0;
    for (int i = 0; i < N; i++) begin
      sic_issue_id[i*IW +: IW] = '0;
      sic_addr[i*30 +: 30]     = 30'h100 + 30'(i);
      sic_wdata[i*32 +: 32]    = 32'hC0DE_0000 + 32'(i);
    end
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] id);
    sic_req[i]               = 1'b1;
    sic_issue_id[i*IW +: IW] = id;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    oldest_id = '0;
    clear_all();
    sic_req   = 4'b1111;
    sic_wen   = 4'b1111;
    #2;
    expect_idle("reset");
    tick();
    clear_all();
    rst_n = 1'b1;
    #3;
    expect_idle("post_reset");
    tick();

    // Single request.
    oldest_id = 6'd3;
    set_req(2, 6'd5);
    #3; expect_idle("single.c0");
    tick();
    sic_release[2] = 1'b1;
    #3; expect_grant("single.c1", 4'b0100, 30'h102, 32'hC0DE_0002, 1'b0);
    tick();
    clear_all();
    #3; expect_idle("single.c2");
    tick();

    // Ordering with back-to-back grants.
    oldest_id = 6'd7;
    set_req(0, 6'd9);
    set_req(1, 6'd7);
    #3; expect_idle("order.c0");
    tick();
    sic_release[1] = 1'b1;
    #3; expect_grant("order.c1", 4'b0010, 30'h101, 32'hC0DE_0001, 1'b0);
    tick();
    sic_req[1] = 1'b0; sic_release[1] = 1'b0; sic_release[0] = 1'b1;
    #3; expect_grant("order.c2", 4'b0001, 30'h100, 32'hC0DE_0000, 1'b0);
    tick();
    clear_all();
    #3; expect_idle("order.c3");
    tick();

    // Wrap-around ages: id 63 is age 1, id 1 is age 3 from oldest 62.
    oldest_id = 6'd62;
    set_req(0, 6'd1);
    set_req(3, 6'd63);
    #3; expect_idle("wrap.c0");
    tick();
    sic_release[3] = 1'b1;
    #3; expect_grant("wrap.c1", 4'b1000, 30'h103, 32'hC0DE_0003, 1'b0);
    tick();
    sic_req[3] = 1'b0; sic_release[3] = 1'b0; sic_release[0] = 1'b1;
    #3; expect_grant("wrap.c2", 4'b0001, 30'h100, 32'hC0DE_0000, 1'b0);
    tick();
    clear_all();
    tick();

    // Abort: owner-elect SIC1 drops its request before the grant cycle.
    oldest_id = 6'd10;
    set_req(0, 6'd20);
    set_req(1, 6'd10);
    #3; expect_idle("abort.c0");
    tick();
    sic_req[1] = 1'b0;
    sic_wen[1] = 1'b1;
    #3; expect_idle("abort.c1");
    tick();
    sic_release[0] = 1'b1;
    #3; expect_grant("abort.c2", 4'b0001, 30'h100, 32'hC0DE_0000, 1'b0);
    tick();
    clear_all();
    tick();

    // Non-preemptive hold; release from a non-owner is ignored.
    oldest_id = 6'd0;
    set_req(2, 6'd30);
    tick();
    set_req(0, 6'd0);
    #3; expect_grant("hold.c1", 4'b0100, 30'h102, 32'hC0DE_0002, 1'b0);
    tick();
    sic_release[0] = 1'b1;
    #3; expect_grant("hold.c2", 4'b0100, 30'h102, 32'hC0DE_0002, 1'b0);
    tick();
    sic_release[0] = 1'b0; sic_release[2] = 1'b1;
    #3; expect_grant("hold.c3", 4'b0100, 30'h102, 32'hC0DE_0002, 1'b0);
    tick();
    sic_req[2] = 1'b0; sic_release[2] = 1'b0; sic_release[0] = 1'b1;
    #3; expect_grant("hold.c4", 4'b0001, 30'h100, 32'hC0DE_0000, 1'b0);
    tick();
    clear_all();
    tick();

    // Write, suppressed by flush, then re-arbitrated.
    set_req(3, 6'd4);
    sic_wen[3]        = 1'b1;
    sic_addr[3*30 +: 30]  = 30'h10;
    sic_wdata[3*32 +: 32] = 32'hDEAD_BEEF;
    #3; expect_idle("write.c0");
    tick();
    #3; expect_grant("write.c1", 4'b1000, 30'h10, 32'hDEAD_BEEF, 1'b1);
    tick();
    flush = 1'b1;
    #3; expect_idle("write.flush");
    tick();
    flush = 1'b0;
    #3; expect_idle("write.rearb");
    tick();
    sic_release[3] = 1'b1;
    #3; expect_grant("write.c4", 4'b1000, 30'h10, 32'hDEAD_BEEF, 1'b1);
    tick();
    clear_all();
    #3; expect_idle("write.c5");
    tick();

    // Asynchronous reset while a grant is active.
    set_req(1, 6'd2);
    sic_wen[1] = 1'b1;
    tick();
    #3; expect_grant("rst.pre", 4'b0010, 30'h101, 32'hC0DE_0001, 1'b1);
    rst_n = 1'b0;
    #1; expect_idle("rst.async");
    tick();
    rst_n = 1'b1;
    #3; expect_idle("rst.rearb");
    tick();
    sic_release[1] = 1'b1;
    #3; expect_grant("rst.regrant", 4'b0010, 30'h101, 32'hC0DE_0001, 1'b1);
    tick();
    clear_all();
    #3; expect_idle("rst.done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
